// File: rtl/wb_pkg.sv
// wb_pkg: shared types for the Wishbone-style single-transfer master.
//   wb_mst_state_t : master FSM encoding (IDLE, REQ, RESP)
//   WB_AW / WB_DW  : default address / data widths of the memory slave
//   wb_rsp_t       : response record {we, err, rdata}, also used by benches
package wb_pkg;

  localparam int WB_AW = 8;
  localparam int WB_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } wb_mst_state_t;

  typedef struct packed {
    logic             we;
    logic             err;
    logic [WB_DW-1:0] rdata;
  } wb_rsp_t;

endpackage

// File: rtl/wb_tmo_cnt.sv
// wb_tmo_cnt: cycle counter that flags when a strobe has been pending too long.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   clear   : restart the count at 0 (takes priority over enable)
//   enable  : advance the count by one this cycle
//   expired : high for the cycle in which an enabled count sits at TIMEOUT-1
module wb_tmo_cnt #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // TIMEOUT is at most 255, so 8 bits always hold TIMEOUT-1.
  logic [7:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  // Decoded from the count register; only meaningful while the master is
  // actually waiting, hence the qualification with enable.
  assign expired = enable && (cnt_reg == 8'(TIMEOUT - 1));

endmodule

// File: rtl/wb_mst.sv
// wb_mst: single-transfer initiator for the 8-bit stb/we/ack memory slave.
//   clk, rst                 : clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready      : user command handshake (ready only in IDLE)
//   cmd_we/cmd_addr/cmd_wdata: command direction, address, write data
//   stb/we/addr/wdata        : bus request, held stable until ack or timeout
//   rdata/ack                : slave read data and acknowledge
//   rsp_valid                : one-cycle response pulse (no backpressure)
//   rsp_we/rsp_rdata/rsp_err : response direction, read data, timeout flag
//   busy                     : high whenever the FSM is not in IDLE
module wb_mst
  import wb_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          stb,
  output logic          we,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata,
  input  logic          ack,
  output logic          rsp_valid,
  output logic          rsp_we,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          busy
);

  wb_mst_state_t state_reg, state_next;

  logic          stb_next, we_next, rsp_valid_next, rsp_we_next, rsp_err_next;
  logic [AW-1:0] addr_next;
  logic [DW-1:0] wdata_next, rsp_rdata_next;
  logic          cnt_clear, cnt_en, cnt_expired;

  wb_tmo_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .expired(cnt_expired)
  );

  // Only combinational output: lets a command in on the very first IDLE cycle.
  assign cmd_ready = (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      stb       <= 1'b0;
      we        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      stb       <= stb_next;
      we        <= we_next;
      addr      <= addr_next;
      wdata     <= wdata_next;
      rsp_valid <= rsp_valid_next;
      rsp_we    <= rsp_we_next;
      rsp_rdata <= rsp_rdata_next;
      rsp_err   <= rsp_err_next;
      busy      <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next     = state_reg;
    stb_next       = stb;
    we_next        = we;
    addr_next      = addr;
    wdata_next     = wdata;
    rsp_valid_next = 1'b0;
    rsp_we_next    = rsp_we;
    rsp_rdata_next = rsp_rdata;
    rsp_err_next   = rsp_err;
    cnt_clear      = 1'b0;
    cnt_en         = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // A stray ack here is simply not looked at.
        if (cmd_valid) begin
          stb_next   = 1'b1;
          we_next    = cmd_we;
          addr_next  = cmd_addr;
          wdata_next = cmd_wdata;
          cnt_clear  = 1'b1;
          state_next = REQ;
        end
      end

      REQ: begin
        cnt_en = 1'b1;
        // ack is tested first so that it wins over a coincident timeout.
        if (ack) begin
          stb_next       = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_we_next    = we;
          rsp_rdata_next = we ? '0 : rdata;
          rsp_err_next   = 1'b0;
          state_next     = RESP;
        end else if (cnt_expired) begin
          stb_next       = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_we_next    = we;
          rsp_rdata_next = '0;
          rsp_err_next   = 1'b1;
          state_next     = RESP;
        end
      end

      RESP: begin
        // rsp_valid falls back to 0 by default; the extra cycle here keeps
        // stb low for two cycles before the next request can start.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        stb_next   = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/wb_mst.md
Name: wb_mst

Overview:
- Wishbone-style single-transfer initiator that drives the existing 8-bit stb/we/ack slave in this codebase.
- Accepts one command at a time from a local user port (valid/ready).
- Drives stb/we/addr/wdata to the slave and holds them until ack or timeout.
- Returns a one-cycle response pulse carrying read data or an error flag.
- Sits between test/control logic and the memory slave; it is the other end of the slave's handshake.

Parameters:
- AW, 8, address width (slave memory depth 2**AW).
- DW, 8, data width.
- TIMEOUT, 16, max cycles stb stays high without ack before abort; legal range 4..255.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- cmd_valid  input  1  user command present.
- cmd_ready  output  1  master can accept a command this cycle.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_addr  input  AW  target address.
- cmd_wdata  input  DW  write data (ignored for reads).
- stb  output  1  strobe to slave.
- we  output  1  write enable to slave.
- addr  output  AW  address to slave.
- wdata  output  DW  write data to slave.
- rdata  input  DW  read data from slave.
- ack  input  1  slave acknowledge.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_we  output  1  echo of the completed command's direction.
- rsp_rdata  output  DW  read data; 0 for writes and for errors.
- rsp_err  output  1  1 = timed out.
- busy  output  1  high whenever not in IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; stb, we, addr, wdata, rsp_valid, rsp_we, rsp_rdata, rsp_err and the timeout count go to 0; cmd_ready=1 on release.
- All outputs are registered except cmd_ready, which equals (state==IDLE).
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - cmd_valid && cmd_ready -> latch we/addr/wdata onto the bus outputs, set stb=1, clear the count, go to REQ.
  - ack seen in IDLE is ignored.
- REQ:
  - stb, we, addr and wdata are held stable; the slave samples addr again in its write state.
  - count increments every cycle.
  - ack=1 sampled -> stb=0 at that same edge; rsp_rdata=(we ? 0 : rdata); rsp_err=0; go to RESP.
  - count==TIMEOUT-1 with no ack -> stb=0, rsp_err=1, rsp_rdata=0, go to RESP.
  - ack and timeout on the same edge -> ack wins, rsp_err=0.
- RESP:
  - rsp_valid=1 for exactly this cycle; rsp_we=latched we; cmd_ready=0.
  - Next edge: rsp_valid=0, go to IDLE.
  - rsp_rdata and rsp_err hold their values until the next response.
- stb is therefore low for at least 2 cycles between transfers (RESP + IDLE), so the slave's check_mode never sees a stale strobe.
- Latency with the slave waiting in check_mode: command accept edge N -> ack high after edge N+2 -> rsp_valid high after edge N+3. Add 1 cycle if the slave was in its idle state.
- No response backpressure: the consumer must take rsp_* during the rsp_valid cycle.
- Reset mid-transfer: stb drops immediately (async), no response is issued, and the in-flight command is lost.
- After a timeout, slave state is undefined until the slave's own reset; the master does not retry.
- Addresses are used as given; no wrap logic, because AW-bit addresses cover the full slave memory.

Decomposition:
- Shared package wb_pkg:
  - typedef enum logic [1:0] wb_mst_state_t {IDLE, REQ, RESP}.
  - localparams WB_AW=8, WB_DW=8.
  - Response struct {we, err, rdata}, shared with the bench.
- One sub-module, wb_tmo_cnt:
  - Inputs: clear, enable.
  - Output: one-cycle expired flag at TIMEOUT-1.
  - Async active-low reset.

Test Plan:
- Write 0xA5 to addr 0x3C, then read 0x3C -> write rsp_valid with rsp_we=1, rsp_err=0; read rsp_rdata=0xA5, rsp_err=0; stb high 3-4 cycles each.
- cmd_valid held high with 4 commands (W 0x01=0x11, W 0x02=0x22, R 0x01, R 0x02) -> cmd_ready low while busy; exactly 4 rsp_valid pulses; reads return 0x11 then 0x22; stb low for ≥2 cycles between transfers.
- ack tied 0, read addr 0x10 with TIMEOUT=16 -> stb drops after 16 cycles; rsp_valid with rsp_err=1, rsp_rdata=0; next command is accepted.
- ack pulsed while IDLE, no command -> no rsp_valid and stb stays 0.
- rst=0 asserted mid-REQ between clock edges -> stb=0 immediately; no rsp_valid; after release cmd_ready=1 and a fresh write/read of 0x7E to 0xFF passes.
- Back-to-back boundary addresses 0x00 and 0xFF written with 0xFF/0x00 -> read back exactly, with no address aliasing.
